// File: rtl/mips_pkg.sv
// Shared types and constants for the mips memory-side blocks.
// Exports: mem_size_t (access size encoding), dmem_state_t (data memory FSM
// states), DMEM_MAX_WAIT (largest wait-state count), DMEM_CNT_W (counter width).
package mips_pkg;

    // Access size as presented by the core; 2'b11 is reserved and faults.
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

    localparam int unsigned DMEM_MAX_WAIT = 15;
    localparam int unsigned DMEM_CNT_W    = $clog2(DMEM_MAX_WAIT + 1);

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian byte-lane steering for the data memory (purely combinational).
// Ports:
//   size     - access size (mem_size_t encoding)
//   ofs      - byte offset within the word (addr[1:0])
//   sign_ext - read extension: 1 sign, 0 zero (ignored for words)
//   wdata    - right-justified write data from the core
//   rword    - stored word being read
//   be       - byte enables, be[3] = bits [31:24]
//   wword    - write data shifted into the addressed lanes
//   rdata    - extracted, right-justified and extended read data
module dmem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  ofs,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Offset 0 is the most significant lane: shift = 8*(3-ofs) for bytes,
    // 16 or 0 for halfwords.
    assign byte_sh = {~ofs, 3'b000};
    assign half_sh = {~ofs[1], 4'b0000};
    assign rd_byte = 8'(rword >> byte_sh);
    assign rd_half = 16'(rword >> half_sh);

    // Lane enables, write shift and read extension per size.
    always_comb begin
        be    = 4'b0000;
        wword = 32'h0;
        rdata = 32'h0;
        case (mem_size_t'(size))
            BYTE: begin
                be    = 4'b1000 >> ofs;
                wword = {24'h0, wdata[7:0]} << byte_sh;
                rdata = sign_ext ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            end
            HALF: begin
                be    = ofs[1] ? 4'b0011 : 4'b1100;
                wword = {16'h0, wdata[15:0]} << half_sh;
                rdata = sign_ext ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            end
            WORD: begin
                be    = 4'b1111;
                wword = wdata;
                rdata = rword;
            end
            default: begin
                be    = 4'b0000;
                wword = 32'h0;
                rdata = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Word-organised big-endian data memory for the mips load/store port.
// One byte/halfword/word access per request with WAIT_STATES extra cycles.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   req                   - access request (sampled in IDLE only)
//   data_rd_wr            - 1 read, 0 write
//   size, sign_ext        - access size, read extension
//   data_addr, data_out   - byte address, right-justified write data
//   data_in               - read data (0 on fault), held outside RESP
//   ready                 - one-cycle completion pulse
//   busy                  - access in progress (WAIT and RESP)
//   fault                 - access rejected, valid with ready
module data_mem
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        data_rd_wr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic        ready,
    output logic        busy,
    output logic        fault
);

    localparam int unsigned          AW       = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_CNT_W-1:0] WAIT_CNT = DMEM_CNT_W'(WAIT_STATES);
    localparam logic [32:0]          LIMIT    = 33'(DEPTH_WORDS) << 2;

    dmem_state_t           state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    logic                  accept;

    logic        cap_rd_q;
    logic [1:0]  cap_size_q;
    logic        cap_sext_q;
    logic [31:0] cap_addr_q;
    logic [31:0] cap_wdata_q;

    logic        acc_rd;
    logic [1:0]  acc_size;
    logic        acc_sext;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    logic [32:0]   off;
    logic [AW-1:0] idx;
    logic          fault_c;
    logic          enter_resp;
    logic          mem_we;
    logic [3:0]    be;
    logic [31:0]   wword;
    logic [31:0]   rword;
    logic [31:0]   rdata;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero wait states RESP is entered straight from IDLE, so the access
    // being completed is the live request rather than the captured one.
    assign acc_rd    = (state_q == IDLE) ? data_rd_wr : cap_rd_q;
    assign acc_size  = (state_q == IDLE) ? size       : cap_size_q;
    assign acc_sext  = (state_q == IDLE) ? sign_ext   : cap_sext_q;
    assign acc_addr  = (state_q == IDLE) ? data_addr  : cap_addr_q;
    assign acc_wdata = (state_q == IDLE) ? data_out   : cap_wdata_q;

    // 33-bit offset: addresses below BASE_ADDR wrap to huge values, never alias.
    assign off = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
    assign idx = off[AW+1:2];

    // Fault check: reserved size, misalignment or out of range.
    always_comb begin
        fault_c = 1'b0;
        case (mem_size_t'(acc_size))
            BYTE:    fault_c = 1'b0;
            HALF:    fault_c = acc_addr[0];
            WORD:    fault_c = (acc_addr[1:0] != 2'b00);
            default: fault_c = 1'b1;
        endcase
        if (off >= LIMIT) begin
            fault_c = 1'b1;
        end
    end

    // Next-state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    cnt_d   = WAIT_CNT;
                    state_d = (WAIT_CNT == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - DMEM_CNT_W'(1);
                if (cnt_q == DMEM_CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Writes commit only on the edge that enters RESP.
    assign enter_resp = (state_d == RESP);
    assign mem_we     = enter_resp && !acc_rd && !fault_c;
    assign rword      = mem[idx];

    dmem_lane_align u_lane_align (
        .size     (acc_size),
        .ofs      (acc_addr[1:0]),
        .sign_ext (acc_sext),
        .wdata    (acc_wdata),
        .rword    (rword),
        .be       (be),
        .wword    (wword),
        .rdata    (rdata)
    );

    // State, captured request and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_rd_q    <= 1'b0;
            cap_size_q  <= 2'b00;
            cap_sext_q  <= 1'b0;
            cap_addr_q  <= 32'h0;
            cap_wdata_q <= 32'h0;
            data_in     <= 32'h0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                cap_rd_q    <= data_rd_wr;
                cap_size_q  <= size;
                cap_sext_q  <= sign_ext;
                cap_addr_q  <= data_addr;
                cap_wdata_q <= data_out;
            end
            ready <= enter_resp;
            busy  <= (state_d != IDLE);
            fault <= enter_resp && fault_c;
            if (enter_resp && (fault_c || acc_rd)) begin
                data_in <= fault_c ? 32'h0 : rdata;
            end
        end
    end

    // Storage array: no reset, contents undefined at power-up.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: expected read data/fault are queued when a
// request is driven and compared when ready pulses.
module tb_data_mem;

    localparam int unsigned WS = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        data_rd_wr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        ready;
    logic        busy;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_din = 32'h0;
    logic [32:0] sb_q[$];

    data_mem #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_STATES (WS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data_rd_wr (data_rd_wr),
        .size       (size),
        .sign_ext   (sign_ext),
        .data_addr  (data_addr),
        .data_out   (data_out),
        .data_in    (data_in),
        .ready      (ready),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [1:0] sz, input logic sx,
                         input logic [31:0] addr, input logic [31:0] wd);
        req        = 1'b1;
        data_rd_wr = rd;
        size       = sz;
        sign_ext   = sx;
        data_addr  = addr;
        data_out   = wd;
    endtask

    // One complete access; for writes the held data_in value is expected.
    task automatic access(input string tag, input logic rd, input logic [1:0] sz,
                          input logic sx, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_d, input logic exp_f);
        logic [32:0] e;
        int cyc;
        logic got;
        logic [31:0] ed;
        ed = exp_f ? 32'h0 : (rd ? exp_d : last_din);
        sb_q.push_back({exp_f, ed});
        last_din = ed;
        drive(rd, sz, sx, addr, wd);
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            req = 1'b0;
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        e = sb_q.pop_front();
        if (!got) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s timeout: observed no ready expected ready", tag);
        end else begin
            check({tag, " data"}, data_in, e[31:0]);
            check({tag, " fault"}, 32'(fault), 32'(e[32]));
            check({tag, " latency"}, 32'(cyc), 32'(WS + 1));
            check({tag, " busy"}, 32'(busy), 32'h1);
            @(negedge clk);
            check({tag, " ready pulse"}, {30'h0, ready, busy}, 32'h0);
        end
    endtask

    initial begin
        int n_ready;
        reset = 1'b0;
        req = 1'b0; data_rd_wr = 1'b0; size = 2'b00; sign_ext = 1'b0;
        data_addr = 32'h0; data_out = 32'h0;
        repeat (3) @(negedge clk);
        check("rst data_in", data_in, 32'h0);
        check("rst ready", 32'(ready), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst fault", 32'(fault), 32'h0);
        reset = 1'b1;

        access("w word", 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        access("r word", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        access("w byte", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0000005A, 32'h0, 1'b0);
        access("r word merge", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDE5ABEEF, 1'b0);
        access("r byte zext", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000005A, 1'b0);
        access("r byte sext", 1'b1, 2'b00, 1'b1, 32'h10, 32'h0, 32'hFFFFFFDE, 1'b0);
        access("r byte lane3", 1'b1, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFFEF, 1'b0);

        access("w half", 1'b0, 2'b01, 1'b0, 32'h12, 32'h00008001, 32'h0, 1'b0);
        access("r half sext", 1'b1, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF8001, 1'b0);
        access("r half hi zext", 1'b1, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000DE5A, 1'b0);
        access("r half misalign", 1'b1, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
        access("w half misalign", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0000FFFF, 32'h0, 1'b1);
        access("r word unchanged", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDE5A8001, 1'b0);
        access("w word misalign", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);

        access("w word oor", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h11223344, 32'h0, 1'b1);
        access("w word last", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0);
        access("r word last", 1'b1, 2'b10, 1'b0, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0);
        access("r word wrap", 1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);
        access("w word wrap", 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0BADBAD0, 32'h0, 1'b1);
        access("r word last again", 1'b1, 2'b10, 1'b0, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0);
        access("size 11", 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);

        // Request during WAIT is ignored: one ready only, and no write.
        drive(1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("wait busy", 32'(busy), 32'h1);
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        n_ready = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req = 1'b0;
            if (ready) begin
                n_ready++;
                check("wait-req data", data_in, 32'hDE5A8001);
            end
        end
        check("wait-req ready count", 32'(n_ready), 32'h1);
        last_din = 32'hDE5A8001;
        access("r after ignored req", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDE5A8001, 1'b0);

        // Reset during WAIT abandons an uncommitted write.
        access("w old 0x20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h11111111, 32'h0, 1'b0);
        drive(1'b0, 2'b10, 1'b0, 32'h20, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        reset = 1'b0;
        #1;
        check("mid rst busy", 32'(busy), 32'h0);
        check("mid rst ready", 32'(ready), 32'h0);
        check("mid rst fault", 32'(fault), 32'h0);
        check("mid rst data_in", data_in, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        last_din = 32'h0;
        access("r 0x20 old", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
